// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit seven-segment driver with BCD/hex load path
// Leading-zero blanking of decimal results is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver #(
    parameter int N_DIGITS     = 4,
    parameter int BIN_W        = 14,
    parameter int DIGIT_CYCLES = 262144,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BIN_W-1:0]    value,
    input  logic                hex_mode,
    input  logic [N_DIGITS-1:0] dp,
    input  logic                load,
    output logic                busy,
    output logic                upd,
    output logic                ovf,
    output logic [N_DIGITS-1:0] an,
    output logic [6:0]          seg,
    output logic                dp_n
);
    localparam int DISP_W = 4 * N_DIGITS;
    localparam int SLOT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;

    logic [BIN_W-1:0]    r_bin;
    logic [DISP_W-1:0]   r_bcd;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_carry;
    logic [DISP_W-1:0]   r_disp;
    logic                r_disp_hex;
    logic                r_upd;
    logic                r_ovf;

    logic [SLOT_W-1:0]   r_slot;
    logic [IDX_W-1:0]    r_idx;
    logic [N_DIGITS-1:0] r_an;
    logic [6:0]          r_seg;
    logic                r_dp_n;

    logic                w_accept;
    logic                w_last;
    logic [DISP_W-1:0]   w_adj;
    logic [DISP_W-1:0]   w_bcd_nx;
    logic                w_carry_nx;
    logic [DISP_W-1:0]   w_hex_val;
    logic [DISP_W-1:0]   w_dec_val;
    logic [3:0]          w_nib;
    logic                w_dp;
    logic [N_DIGITS-1:0] w_an;
    logic                w_active;
    logic [6:0]          w_glyph;

    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b0000001;
            4'h1:    g = 7'b1001111;
            4'h2:    g = 7'b0010010;
            4'h3:    g = 7'b0000110;
            4'h4:    g = 7'b1001100;
            4'h5:    g = 7'b0100100;
            4'h6:    g = 7'b0100000;
            4'h7:    g = 7'b0001111;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0000100;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b1100000;
            4'hC:    g = 7'b0110001;
            4'hD:    g = 7'b1000010;
            4'hE:    g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

    assign w_last = (r_cnt == CNT_W'(1));

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_accept = 1'b1;
                    if (!hex_mode) begin
                        w_state_nx = S_CONV;
                    end
                end
            end
            S_CONV: begin
                if (w_last) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Shift-and-add-3: correct every nibble >= 5, then shift the next binary bit in.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_bcd_nx   = {w_adj[DISP_W-2:0], r_bin[BIN_W-1]};
        w_carry_nx = w_adj[DISP_W-1];
    end

    always_comb begin
        w_hex_val              = '0;
        w_hex_val[BIN_W-1:0]   = value;
    end

`ifdef SEG7_LZB_EN
    logic w_lead;

    always_comb begin
        w_dec_val = w_bcd_nx;
        w_lead    = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            if (w_lead && (w_bcd_nx[4*i +: 4] == 4'd0)) begin
                w_dec_val[4*i +: 4] = 4'hF;
            end else begin
                w_lead = 1'b0;
            end
        end
    end
`else
    assign w_dec_val = w_bcd_nx;
`endif

    // r_carry latches any digit pushed out of the top nibble: the result exceeded N_DIGITS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_disp     <= '0;
            r_disp_hex <= 1'b0;
            r_upd      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (w_accept) begin
                if (hex_mode) begin
                    r_disp     <= w_hex_val;
                    r_disp_hex <= 1'b1;
                    r_ovf      <= 1'b0;
                    r_upd      <= 1'b1;
                end else begin
                    r_bin   <= value;
                    r_bcd   <= '0;
                    r_cnt   <= CNT_W'(BIN_W);
                    r_carry <= 1'b0;
                end
            end else if (r_state == S_CONV) begin
                r_bin   <= r_bin << 1;
                r_bcd   <= w_bcd_nx;
                r_carry <= r_carry | w_carry_nx;
                r_cnt   <= r_cnt - CNT_W'(1);
                if (w_last) begin
                    r_disp     <= w_dec_val;
                    r_disp_hex <= 1'b0;
                    r_ovf      <= r_carry | w_carry_nx;
                    r_upd      <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= '0;
            r_idx  <= '0;
        end else if (r_slot == SLOT_W'(DIGIT_CYCLES - 1)) begin
            r_slot <= '0;
            r_idx  <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_slot <= r_slot + SLOT_W'(1);
        end
    end

    always_comb begin
        w_nib = 4'd0;
        w_dp  = 1'b0;
        w_an  = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib   = r_disp[4*i +: 4];
                w_dp    = dp[i];
                w_an[i] = 1'b0;
            end
        end
        w_active = (r_slot >= SLOT_W'(BLANK_CYCLES));
    end

    // 4'hF only ever reaches a decimal display as the leading-zero blank marker.
    always_comb begin
        if (r_ovf) begin
            w_glyph = SEG_DASH;
        end else if (!r_disp_hex && (w_nib == 4'hF)) begin
            w_glyph = SEG_BLANK;
        end else begin
            w_glyph = f_glyph(w_nib);
        end
    end

    // Cathodes are also blanked in the dead window so no glyph ghosts onto the next digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an   <= '1;
            r_seg  <= SEG_BLANK;
            r_dp_n <= 1'b1;
        end else if (w_active) begin
            r_an   <= w_an;
            r_seg  <= w_glyph;
            r_dp_n <= ~w_dp;
        end else begin
            r_an   <= '1;
            r_seg  <= SEG_BLANK;
            r_dp_n <= 1'b1;
        end
    end

    assign busy = (r_state == S_CONV);
    assign upd  = r_upd;
    assign ovf  = r_ovf;
    assign an   = r_an;
    assign seg  = r_seg;
    assign dp_n = r_dp_n;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;
    localparam int ND = 4;
    localparam int BW = 14;
    localparam int DC = 40;
    localparam int BC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [BW-1:0] value;
    logic          hex_mode;
    logic [ND-1:0] dp;
    logic          load;
    logic          busy;
    logic          upd;
    logic          ovf;
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp_n;

    int total = 0;
    int bad   = 0;

    seg7_scan_driver #(
        .N_DIGITS    (ND),
        .BIN_W       (BW),
        .DIGIT_CYCLES(DC),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .value   (value),
        .hex_mode(hex_mode),
        .dp      (dp),
        .load    (load),
        .busy    (busy),
        .upd     (upd),
        .ovf     (ovf),
        .an      (an),
        .seg     (seg),
        .dp_n    (dp_n)
    );

    always #5 clk = ~clk;

    task automatic load_val(input logic [BW-1:0] v, input logic hx);
        @(negedge clk);
        value    = v;
        hex_mode = hx;
        load     = 1'b1;
        @(posedge clk);
        #1 load  = 1'b0;
    endtask

    task automatic wait_digit(input int d, output logic [6:0] s, output logic dpn, output bit ok);
        logic [ND-1:0] want;
        want    = '1;
        want[d] = 1'b0;
        ok      = 1'b0;
        s       = 'x;
        dpn     = 1'bx;
        for (int k = 0; k < ND*DC + DC; k++) begin
            @(negedge clk);
            if (an === want) begin
                s   = seg;
                dpn = dp_n;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (an !== 4'b1111)      begin bad++; $display("FAIL reset_an got=%b exp=1111", an); end
        total++; if (seg !== 7'b1111111)  begin bad++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
        total++; if (dp_n !== 1'b1)       begin bad++; $display("FAIL reset_dp_n got=%b exp=1", dp_n); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (upd !== 1'b0)        begin bad++; $display("FAIL reset_upd got=%b exp=0", upd); end
        total++; if (ovf !== 1'b0)        begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_scan;
        int slot, idx, shown;
        logic [ND-1:0] exp_an;
        shown = 0;
        dp    = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= ND*DC + DC; k++) begin
            @(negedge clk);
            slot   = (k - 1) % DC;
            idx    = ((k - 1) / DC) % ND;
            exp_an = '1;
            if (slot >= BC) exp_an[idx] = 1'b0;
            total++;
            if (an !== exp_an) begin
                bad++;
                if (shown < 5) $display("FAIL scan_an cycle=%0d got=%b exp=%b", k, an, exp_an);
                shown++;
            end
            if (slot >= BC) begin
                total++;
                if (seg !== 7'b0000001 || dp_n !== 1'b1) begin
                    bad++;
                    if (shown < 5) $display("FAIL scan_seg cycle=%0d got=%b/%b exp=0000001/1", k, seg, dp_n);
                    shown++;
                end
            end
        end
    endtask

    task automatic test_dp;
        logic [6:0] s;
        logic       dpn;
        bit         ok;
        logic       exp_dpn;
        int         shown;
        shown = 0;
        dp    = 4'b0100;
        @(negedge clk);
        for (int k = 0; k < ND*DC + DC; k++) begin
            @(negedge clk);
            exp_dpn = (an === 4'b1011) ? 1'b0 : 1'b1;
            total++;
            if (dp_n !== exp_dpn) begin
                bad++;
                if (shown < 5) $display("FAIL dp_follow an=%b got=%b exp=%b", an, dp_n, exp_dpn);
                shown++;
            end
        end
        wait_digit(2, s, dpn, ok);
        total++; if (!ok || dpn !== 1'b0) begin bad++; $display("FAIL dp_sel got=%b exp=0", dpn); end
        dp = 4'b0000;
        @(negedge clk);
        total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL dp_live_off got=%b exp=1", dp_n); end
        dp = 4'b0100;
        @(negedge clk);
        total++; if (dp_n !== 1'b0) begin bad++; $display("FAIL dp_live_on got=%b exp=0", dp_n); end
        dp = 4'b0000;
    endtask

    task automatic test_decimal;
        int busy_cnt, upd_cnt, upd_at;
        logic [6:0] exp_d [ND];
        logic [6:0] s;
        logic       dpn;
        bit         ok;
        busy_cnt = 0; upd_cnt = 0; upd_at = -1;
        load_val(14'd1234, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (upd === 1'b1) begin upd_cnt++; if (upd_at < 0) upd_at = i; end
        end
        total++; if (busy_cnt != BW)     begin bad++; $display("FAIL dec_busy_len got=%0d exp=%0d", busy_cnt, BW); end
        total++; if (upd_cnt != 1)       begin bad++; $display("FAIL dec_upd_cnt got=%0d exp=1", upd_cnt); end
        total++; if (upd_at != BW + 1)   begin bad++; $display("FAIL dec_upd_at got=%0d exp=%0d", upd_at, BW + 1); end
        total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL dec_ovf got=%b exp=0", ovf); end
        exp_d[3] = 7'b1001111; exp_d[2] = 7'b0010010; exp_d[1] = 7'b0000110; exp_d[0] = 7'b1001100;
        for (int d = ND - 1; d >= 0; d--) begin
            wait_digit(d, s, dpn, ok);
            total++;
            if (!ok || s !== exp_d[d]) begin bad++; $display("FAIL dec_digit%0d got=%b exp=%b", d, s, exp_d[d]); end
        end
    endtask

    task automatic test_hex;
        int busy_cnt, upd_cnt, upd_at;
        logic [6:0] exp_d [ND];
        logic [6:0] s;
        logic       dpn;
        bit         ok;
        busy_cnt = 0; upd_cnt = 0; upd_at = -1;
        load_val(14'h3BEF, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (upd === 1'b1) begin upd_cnt++; if (upd_at < 0) upd_at = i; end
        end
        total++; if (busy_cnt != 0) begin bad++; $display("FAIL hex_busy got=%0d exp=0", busy_cnt); end
        total++; if (upd_cnt != 1)  begin bad++; $display("FAIL hex_upd_cnt got=%0d exp=1", upd_cnt); end
        total++; if (upd_at != 1)   begin bad++; $display("FAIL hex_upd_at got=%0d exp=1", upd_at); end
        exp_d[3] = 7'b0000110; exp_d[2] = 7'b1100000; exp_d[1] = 7'b0110000; exp_d[0] = 7'b0111000;
        for (int d = ND - 1; d >= 0; d--) begin
            wait_digit(d, s, dpn, ok);
            total++;
            if (!ok || s !== exp_d[d]) begin bad++; $display("FAIL hex_digit%0d got=%b exp=%b", d, s, exp_d[d]); end
        end
    endtask

    task automatic test_overflow;
        logic [6:0] exp_d [ND];
        logic [6:0] s;
        logic       dpn;
        bit         ok;
        load_val(14'd12000, 1'b0);
        repeat (BW + 2) @(negedge clk);
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf); end
        for (int d = ND - 1; d >= 0; d--) begin
            wait_digit(d, s, dpn, ok);
            total++;
            if (!ok || s !== 7'b1111110) begin bad++; $display("FAIL ovf_dash%0d got=%b exp=1111110", d, s); end
        end
        load_val(14'd42, 1'b0);
        repeat (BW + 2) @(negedge clk);
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
`ifdef SEG7_LZB_EN
        exp_d[3] = 7'b1111111; exp_d[2] = 7'b1111111;
`else
        exp_d[3] = 7'b0000001; exp_d[2] = 7'b0000001;
`endif
        exp_d[1] = 7'b1001100; exp_d[0] = 7'b0010010;
        for (int d = ND - 1; d >= 0; d--) begin
            wait_digit(d, s, dpn, ok);
            total++;
            if (!ok || s !== exp_d[d]) begin bad++; $display("FAIL v42_digit%0d got=%b exp=%b", d, s, exp_d[d]); end
        end
    endtask

    task automatic test_back_to_back;
        int upd_cnt, upd1, upd2;
        logic busy_after;
        logic [6:0] s;
        logic       dpn;
        bit         ok;
        upd_cnt = 0; upd1 = -1; upd2 = -1; busy_after = 1'b0;
        @(negedge clk);
        value    = 14'd1234;
        hex_mode = 1'b0;
        load     = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (upd === 1'b1) begin
                upd_cnt++;
                if (upd1 < 0) upd1 = i; else if (upd2 < 0) upd2 = i;
            end
            if (i == BW + 2) busy_after = busy;
            value = 14'd5678;
            load  = (i <= BW + 1) ? 1'b1 : 1'b0;
        end
        total++; if (upd_cnt != 2)     begin bad++; $display("FAIL b2b_upd_cnt got=%0d exp=2", upd_cnt); end
        total++; if (upd1 != BW + 1)   begin bad++; $display("FAIL b2b_upd1 got=%0d exp=%0d", upd1, BW + 1); end
        total++; if (upd2 != 2*BW + 2) begin bad++; $display("FAIL b2b_upd2 got=%0d exp=%0d", upd2, 2*BW + 2); end
        total++; if (busy_after !== 1'b1) begin bad++; $display("FAIL b2b_reaccept got=%b exp=1", busy_after); end
        wait_digit(3, s, dpn, ok);
        total++; if (!ok || s !== 7'b0100100) begin bad++; $display("FAIL b2b_digit3 got=%b exp=0100100", s); end
        wait_digit(0, s, dpn, ok);
        total++; if (!ok || s !== 7'b0000000) begin bad++; $display("FAIL b2b_digit0 got=%b exp=0000000", s); end
    endtask

    task automatic test_reset_mid;
        int upd_cnt, busy_cnt;
        logic [6:0] s;
        logic       dpn;
        bit         ok;
        upd_cnt = 0; busy_cnt = 0;
        load_val(14'd9876, 1'b0);
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_pre got=%b exp=1", busy); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
        total++; if (an !== 4'b1111)     begin bad++; $display("FAIL mid_an got=%b exp=1111", an); end
        total++; if (seg !== 7'b1111111) begin bad++; $display("FAIL mid_seg got=%b exp=1111111", seg); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (upd === 1'b1) upd_cnt++;
            if (busy === 1'b1) busy_cnt++;
        end
        total++; if (upd_cnt != 0)  begin bad++; $display("FAIL mid_no_upd got=%0d exp=0", upd_cnt); end
        total++; if (busy_cnt != 0) begin bad++; $display("FAIL mid_no_busy got=%0d exp=0", busy_cnt); end
        wait_digit(0, s, dpn, ok);
        total++; if (!ok || s !== 7'b0000001) begin bad++; $display("FAIL mid_cleared got=%b exp=0000001", s); end
    endtask

    initial begin
        rst_n    = 1'b0;
        value    = '0;
        hex_mode = 1'b0;
        dp       = '0;
        load     = 1'b0;
        test_reset;
        test_scan;
        test_dp;
        test_decimal;
        test_hex;
        test_overflow;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
